// File: rtl/event_reporter_mc.sv
// Event reporter: timestamps masked event strobes, queues groups in a FIFO and
// emits one AXI-Stream beat per event in each group.
module event_reporter_mc #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HEADER     = 8'h01
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_EVENTS-1:0] event_strobe,
  input  logic [NUM_EVENTS-1:0] event_enable,
  output logic [255:0]          AXIS_OUT_TDATA,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  input  logic                  AXIS_OUT_TREADY,
  output logic [15:0]           drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = NUM_EVENTS + 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [31:0]           ts_q;
  logic [NUM_EVENTS-1:0] stg_mask_q;
  logic [31:0]           stg_ts_q;
  logic                  stg_pend_q;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic                  fifo_full_c;
  logic                  fifo_empty_c;
  logic                  fifo_wr_c;
  logic [EW-1:0]         fifo_head_c;

  logic [0:0]            state_q, state_d;
  logic [NUM_EVENTS-1:0] grp_q, grp_d;
  logic [31:0]           gts_q, gts_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [255:0]          tdata_q, tdata_d;
  logic [15:0]           drop_q;
  logic                  pop_c;
  logic [NUM_EVENTS-1:0] low_oh_c;
  logic [NUM_EVENTS-1:0] rem_c;

  // Code (index + 1) of the lowest set bit; 0 when no bit is set.
  function automatic logic [7:0] low_code(input logic [NUM_EVENTS-1:0] v);
    low_code = 8'd0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (v[i]) low_code = 8'(i + 1);
    end
  endfunction

  assign fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_wr_c    = stg_pend_q && !fifo_full_c;
  assign fifo_head_c  = mem[rd_ptr_q[AW-1:0]];

  assign low_oh_c = grp_q & (~grp_q + NUM_EVENTS'(1));
  assign rem_c    = grp_q & ~low_oh_c;

  // FIFO storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (fifo_wr_c) mem[wr_ptr_q[AW-1:0]] <= {stg_mask_q, stg_ts_q};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and beat generation; the next beat loads as soon as the
  // output register is free or its current beat is being accepted.
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    gts_d    = gts_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    pop_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          grp_d   = fifo_head_c[EW-1:32];
          gts_d   = fifo_head_c[31:0];
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!tvalid_q || AXIS_OUT_TREADY) begin
          if (tvalid_q && tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            grp_d    = rem_c;
            tvalid_d = 1'b1;
            tlast_d  = (rem_c == '0);
            tdata_d  = {HEADER, 200'd0, gts_q, 8'd0, low_code(grp_q)};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timestamp, staging, FIFO pointers, drop counter and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_q       <= 32'd0;
      stg_mask_q <= '0;
      stg_ts_q   <= 32'd0;
      stg_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= 16'd0;
      grp_q      <= '0;
      gts_q      <= 32'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= 256'd0;
    end else begin
      ts_q       <= ts_q + 32'd1;
      stg_mask_q <= event_strobe & event_enable;
      stg_ts_q   <= ts_q;
      stg_pend_q <= |(event_strobe & event_enable);
      if (fifo_wr_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (stg_pend_q && fifo_full_c && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      grp_q      <= grp_d;
      gts_q      <= gts_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign AXIS_OUT_TDATA  = tdata_q;
  assign AXIS_OUT_TVALID = tvalid_q;
  assign AXIS_OUT_TLAST  = tlast_q;
  assign drop_count      = drop_q;

endmodule
